// File: rtl/modcounter.sv
// modcounter: N-bit up/down counter with programmable terminal value,
// parallel load, count enable and wrap or saturate at the range boundary.
module modcounter #(
  parameter int unsigned N        = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic [N-1:0] max,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         ovf
);

  logic         at_top;
  logic         at_bot;
  logic         boundary;
  logic [N-1:0] q_next;
  logic         ovf_next;

  // Boundary detection: q at or past the terminal going up, or at zero going down.
  always_comb begin
    at_top   = (q >= max);
    at_bot   = (q == '0);
    boundary = en & ~load & ((up & at_top) | (~up & at_bot));
    tc       = boundary & ~reset;
  end

  // Next count and sticky flag for the load / count / hold cases.
  always_comb begin
    q_next   = q;
    ovf_next = ovf;
    if (load) begin
      q_next   = d;
      ovf_next = 1'b0;
    end else if (en) begin
      if (boundary) begin
        ovf_next = 1'b1;
      end
      if (up) begin
        if (q < max) begin
          q_next = q + N'(1);
        end else if ((q == max) && SATURATE) begin
          q_next = q;
        end else begin
          // Wrap at max, or recover from an out-of-range loaded value.
          q_next = '0;
        end
      end else begin
        if (!at_bot) begin
          q_next = q - N'(1);
        end else if (SATURATE) begin
          q_next = '0;
        end else begin
          q_next = max;
        end
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_modcounter.sv
// Testbench for modcounter: directed scenarios plus random stimulus, all
// checked against an arithmetic reference model of the counting rules.
module tb_modcounter;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [3:0] d4, max4;
  logic [7:0] d8, max8;
  logic [3:0] qa, qb, q_lo, q_hi;
  logic [7:0] qc;
  logic       tca, tcb, tcc, tc_lo, tc_hi;
  logic       ovfa, ovfb, ovfc, ovf_lo, ovf_hi;
  logic       casc_reset;

  int n_checks = 0;
  int n_errors = 0;

  int mq[3];
  bit mo[3];
  int casc_cnt;

  always #5 clk = ~clk;

  modcounter #(.N(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .d(d4), .max(max4), .q(qa), .tc(tca), .ovf(ovfa));

  modcounter #(.N(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .d(d4), .max(max4), .q(qb), .tc(tcb), .ovf(ovfb));

  modcounter #(.N(8), .SATURATE(1'b0)) u_wide (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .d(d8), .max(max8), .q(qc), .tc(tcc), .ovf(ovfc));

  modcounter #(.N(4), .SATURATE(1'b0)) u_lo (
    .clk(clk), .reset(casc_reset), .en(1'b1), .up(1'b1), .load(1'b0),
    .d(4'd0), .max(4'd15), .q(q_lo), .tc(tc_lo), .ovf(ovf_lo));

  modcounter #(.N(4), .SATURATE(1'b0)) u_hi (
    .clk(clk), .reset(casc_reset), .en(tc_lo), .up(1'b1), .load(1'b0),
    .d(4'd0), .max(4'd15), .q(q_hi), .tc(tc_hi), .ovf(ovf_hi));

  // Compare one observed value against the expected one.
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference terminal-count strobe.
  function automatic bit ref_tc(bit r, bit l, bit e, bit u, int q, int mx);
    return !r && e && !l && ((u && q >= mx) || (!u && q == 0));
  endfunction

  // Reference next state from the counting rules.
  task automatic ref_next(input bit r, input bit l, input bit e, input bit u,
                          input int dv, input int mx, input bit sat,
                          inout int q, inout bit o);
    if (r) begin
      q = 0; o = 1'b0;
    end else if (l) begin
      q = dv; o = 1'b0;
    end else if (e) begin
      if (ref_tc(r, l, e, u, q, mx)) o = 1'b1;
      if (u) begin
        if (q < mx) q = q + 1;
        else if (q == mx && sat) q = q;
        else q = 0;
      end else begin
        if (q > 0) q = q - 1;
        else if (!sat) q = mx;
      end
    end
  endtask

  // Apply one cycle of inputs starting at a falling edge, check tc before
  // the rising edge and q/ovf after it.
  task automatic step(input bit r, input bit l, input bit e, input bit u,
                      input int dv, input int mv);
    int dd, mm;
    reset = r; load = l; en = e; up = u;
    d8 = 8'(dv); max8 = 8'(mv);
    d4 = 4'(dv); max4 = 4'(mv);
    #1;
    for (int i = 0; i < 3; i++) begin
      dd = (i == 2) ? (dv & 255) : (dv & 15);
      mm = (i == 2) ? (mv & 255) : (mv & 15);
      case (i)
        0: check("tc_wrap", int'(tca), int'(ref_tc(r, l, e, u, mq[i], mm)));
        1: check("tc_sat",  int'(tcb), int'(ref_tc(r, l, e, u, mq[i], mm)));
        default: check("tc_wide", int'(tcc), int'(ref_tc(r, l, e, u, mq[i], mm)));
      endcase
      ref_next(r, l, e, u, dd, mm, (i == 1), mq[i], mo[i]);
    end
    casc_cnt = casc_reset ? 0 : ((casc_cnt + 1) & 255);
    @(negedge clk);
    check("q_wrap",   int'(qa),   mq[0]);
    check("ovf_wrap", int'(ovfa), int'(mo[0]));
    check("q_sat",    int'(qb),   mq[1]);
    check("ovf_sat",  int'(ovfb), int'(mo[1]));
    check("q_wide",   int'(qc),   mq[2]);
    check("ovf_wide", int'(ovfc), int'(mo[2]));
    if (!casc_reset) check("cascade", int'({q_hi, q_lo}), casc_cnt);
    casc_reset = 1'b0;
  endtask

  initial begin
    int m, sel;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
    d4 = '0; max4 = '0; d8 = '0; max8 = '0;
    casc_reset = 1'b1;
    casc_cnt = 0;
    for (int i = 0; i < 3; i++) begin mq[i] = 0; mo[i] = 1'b0; end
    @(negedge clk);

    // Wrap up through max=9.
    step(1, 0, 0, 1, 0, 9);
    check("reset_q", int'(qa), 0);
    check("reset_ovf", int'(ovfa), 0);
    for (int k = 0; k < 9; k++) step(0, 0, 1, 1, 0, 9);
    check("wrap_q9", int'(qa), 9);
    check("wrap_ovf_pre", int'(ovfa), 0);
    check("wrap_tc9", int'(tca), 1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0, 9);
    check("wrap_q2", int'(qa), 2);
    check("wrap_ovf_post", int'(ovfa), 1);

    // Down from 0 with max=5: wrap vs saturate.
    step(1, 0, 0, 0, 0, 5);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 5);
    check("down_wrap_q", int'(qa), 3);
    check("down_sat_q", int'(qb), 0);
    check("down_sat_tc", int'(tcb), 1);
    check("down_sat_ovf", int'(ovfb), 1);

    // Out-of-range load, then up and down behaviour.
    step(0, 1, 1, 1, 13, 9);
    check("load_q", int'(qa), 13);
    check("load_ovf", int'(ovfa), 0);
    step(0, 0, 1, 1, 0, 9);
    check("oor_up_q", int'(qa), 0);
    check("oor_up_ovf", int'(ovfa), 1);
    step(0, 1, 1, 1, 13, 9);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 9);
    check("oor_down_q", int'(qa), 9);
    check("oor_down_ovf", int'(ovfa), 0);

    // Reset beats a simultaneous load; idle keeps zero.
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0, 9);
    step(1, 1, 1, 1, 3, 9);
    check("rst_load_q", int'(qa), 0);
    check("rst_load_tc", int'(tca), 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 9);
    check("idle_q", int'(qa), 0);

    // Full 8-bit range.
    step(0, 1, 0, 1, 254, 255);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0, 255);
    check("full_q", int'(qc), 1);
    check("full_ovf", int'(ovfc), 1);

    // Degenerate max=0.
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0, 0);
    check("max0_q", int'(qa), 0);
    check("max0_tc", int'(tca), 1);
    check("max0_ovf", int'(ovfb), 1);

    // Random stimulus.
    for (int k = 0; k < 1500; k++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) m = 0;
      else if (sel == 1) m = 255;
      else m = int'($urandom_range(0, 255));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)), m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
